// File: rtl/single_log2_range_reduce_if.sv
// Handshake and data bundle for the single-precision log2 range-reduction stage.
// The master modport is the side that supplies operands and consumes results.
interface single_log2_range_reduce_if #(
    parameter int BITS = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] m_out;
    logic [8:0]      exp_out;
    logic [3:0]      flags;
    logic            busy;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, m_out, exp_out, flags, busy
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, m_out, exp_out, flags, busy
    );
endinterface

// File: rtl/single_log2_range_reduce.sv
// Splits an IEEE-754 single into an unbiased exponent and a [1.0, 2.0) mantissa; two-stage valid/ready pipe.
// SINGLE_LOG2_DENORM_EN: when defined, denormals are normalised; otherwise they are flushed to zero.
module single_log2_range_reduce #(
    parameter int    BITS      = 32,
    parameter string PRECISION = "SINGLE"
) (
    input  logic clk,
    input  logic reset,
    single_log2_range_reduce_if.slave bus
);
    localparam logic [31:0] ONE = 32'h3F80_0000;

    generate
        if (BITS != 32 || PRECISION != "SINGLE") begin : g_bad_cfg
            $error("single_log2_range_reduce supports only BITS=32, PRECISION=SINGLE");
        end
    endgenerate

    logic        s1_valid_reg;
    logic        s1_sign_reg;
    logic [7:0]  s1_exp_reg;
    logic [22:0] s1_man_reg;

    logic        out_valid_reg;
    logic [31:0] m_out_reg;
    logic [8:0]  exp_out_reg;
    logic [3:0]  flags_reg;

    logic        s2_adv;
    logic        in_ready;

    // No skid buffer: stage 1 may only refill when stage 2 is draining or empty.
    assign s2_adv   = !out_valid_reg || bus.out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;

`ifdef SINGLE_LOG2_DENORM_EN
    logic [4:0] lz_next;
    logic [4:0] s1_lz_reg;

    // Highest set mantissa bit wins; 23 when the mantissa is empty.
    always_comb begin
        lz_next = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (bus.a[i]) lz_next = 5'(22 - i);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_man_reg   <= '0;
`ifdef SINGLE_LOG2_DENORM_EN
            s1_lz_reg    <= '0;
`endif
        end else if (in_ready) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_reg <= bus.a[31];
                s1_exp_reg  <= bus.a[30:23];
                s1_man_reg  <= bus.a[22:0];
`ifdef SINGLE_LOG2_DENORM_EN
                s1_lz_reg   <= lz_next;
`endif
            end
        end
    end

    logic        is_nan;
    logic        is_zero;
    logic        man_zero;
    logic [31:0] m_next;
    logic [8:0]  exp_next;
    logic [3:0]  flags_next;

    assign man_zero = (s1_man_reg == 23'd0);
    assign is_nan   = (s1_exp_reg == 8'hFF) && !man_zero;
`ifdef SINGLE_LOG2_DENORM_EN
    assign is_zero  = (s1_exp_reg == 8'h00) && man_zero;
`else
    // Denormals of either sign collapse into the zero class.
    assign is_zero  = (s1_exp_reg == 8'h00);
`endif

    always_comb begin
        m_next     = ONE;
        exp_next   = '0;
        flags_next = '0;
        if (is_nan) begin
            flags_next = 4'b1000;
        end else if (is_zero) begin
            flags_next = 4'b0001;
        end else if (s1_sign_reg) begin
            flags_next = 4'b0010;
        end else if (s1_exp_reg == 8'hFF) begin
            flags_next = 4'b0100;
`ifdef SINGLE_LOG2_DENORM_EN
        end else if (s1_exp_reg == 8'h00) begin
            // Shift past the leading one so it becomes the implicit bit.
            m_next   = {1'b0, 8'd127, s1_man_reg << (s1_lz_reg + 5'd1)};
            exp_next = 9'd0 - 9'd127 - {4'b0000, s1_lz_reg};
`endif
        end else begin
            m_next   = {1'b0, 8'd127, s1_man_reg};
            exp_next = {1'b0, s1_exp_reg} - 9'd127;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            m_out_reg     <= '0;
            exp_out_reg   <= '0;
            flags_reg     <= '0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                m_out_reg   <= m_next;
                exp_out_reg <= exp_next;
                flags_reg   <= flags_next;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.m_out     = m_out_reg;
    assign bus.exp_out   = exp_out_reg;
    assign bus.flags     = flags_reg;
    assign bus.busy      = s1_valid_reg | out_valid_reg;
endmodule

// File: tb/tb_single_log2_range_reduce.sv
// Self-checking bench for single_log2_range_reduce: directed vector table, stall/reset sequences
// and a randomized stream scored against an arithmetic reference model.
module tb_single_log2_range_reduce;
`ifdef SINGLE_LOG2_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] m;
        logic [8:0]  e;
        logic [3:0]  f;
    } res_t;

    typedef struct {
        logic [31:0] a;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    single_log2_range_reduce_if #(.BITS(32)) bus ();

    single_log2_range_reduce #(.BITS(32), .PRECISION("SINGLE")) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   compared = 0;
    int   mismatched = 0;
    int   out_cnt = 0;
    bit   mon_en = 1'b0;
    res_t exp_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: classify by value, then normalise a denormal by doubling until it reaches 2^23.
    function automatic res_t model(input logic [31:0] x);
        res_t r;
        int   ex;
        int   mn;
        int   e;
        int   m;
        ex  = int'(x[30:23]);
        mn  = int'(x[22:0]);
        r.m = 32'h3F80_0000;
        r.e = '0;
        r.f = '0;
        if (ex == 255 && mn != 0)                r.f = 4'b1000;
        else if (ex == 0 && (mn == 0 || !DENORM)) r.f = 4'b0001;
        else if (x[31])                           r.f = 4'b0010;
        else if (ex == 255)                       r.f = 4'b0100;
        else if (ex == 0) begin
            m = mn;
            e = -126;
            while (m < 32'h0080_0000) begin
                m = m * 2;
                e = e - 1;
            end
            r.m = {1'b0, 8'd127, m[22:0]};
            r.e = 9'(e);
        end else begin
            r.m = {1'b0, 8'd127, x[22:0]};
            r.e = 9'(ex - 127);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 7))
            0: x[30:23] = 8'h00;
            1: x[30:0]  = 31'h0000_0000;
            2: x[30:23] = 8'hFF;
            3: x[30:0]  = 31'h7F80_0000;
            default: ;
        endcase
        return x;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] m, input logic [8:0] e, input logic [3:0] f);
        vec_t v;
        v.a = a;
        v.r.m = m;
        v.r.e = e;
        v.r.f = f;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction through an empty pipe; out_valid must appear two edges after presentation.
    task automatic run_vec(input vec_t v);
        int cyc;
        bus.a = v.a;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk($sformatf("latency a=%h", v.a), 64'(cyc), 64'd2);
        chk($sformatf("m_out a=%h", v.a), 64'(bus.m_out), 64'(v.r.m));
        chk($sformatf("exp_out a=%h", v.a), 64'(bus.exp_out), 64'(v.r.e));
        chk($sformatf("flags a=%h", v.a), 64'(bus.flags), 64'(v.r.f));
        $display("vec a=%h m_out=%h exp_out=%0d flags=%b", v.a, bus.m_out, $signed(bus.exp_out), bus.flags);
        tick();
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        res_t exp_r;
        res_t prev;
        res_t cur;
        bit   hold_prev;
        hold_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {bus.m_out, bus.exp_out, bus.flags};
            if (reset || !mon_en) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) chk("stall hold", 64'(cur), 64'(prev));
                if (bus.out_valid && bus.out_ready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected output", 64'(cur), 64'hDEAD);
                    end else begin
                        exp_r = exp_q.pop_front();
                        chk("stream result", 64'(cur), 64'(exp_r));
                        $display("out m_out=%h exp_out=%0d flags=%b", bus.m_out, $signed(bus.exp_out), bus.flags);
                    end
                end
                hold_prev = bus.out_valid && !bus.out_ready;
                prev = cur;
                if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.out_ready = 1'b1;

        vecs.push_back(mk(32'h4040_0000, 32'h3FC0_0000, 9'd1,   4'b0000));
        vecs.push_back(mk(32'h3F80_0000, 32'h3F80_0000, 9'd0,   4'b0000));
        vecs.push_back(mk(32'h8000_0000, 32'h3F80_0000, 9'd0,   4'b0001));
        vecs.push_back(mk(32'hBF80_0000, 32'h3F80_0000, 9'd0,   4'b0010));
        vecs.push_back(mk(32'h7F80_0000, 32'h3F80_0000, 9'd0,   4'b0100));
        vecs.push_back(mk(32'h7FC0_0000, 32'h3F80_0000, 9'd0,   4'b1000));
        vecs.push_back(mk(32'hFF80_0000, 32'h3F80_0000, 9'd0,   4'b0010));
        vecs.push_back(mk(32'h0000_0000, 32'h3F80_0000, 9'd0,   4'b0001));
        vecs.push_back(mk(32'h7F7F_FFFF, 32'h3FFF_FFFF, 9'd127, 4'b0000));
        vecs.push_back(mk(32'h0080_0000, 32'h3F80_0000, 9'(-126), 4'b0000));
        if (DENORM) begin
            vecs.push_back(mk(32'h0000_0001, 32'h3F80_0000, 9'(-149), 4'b0000));
            vecs.push_back(mk(32'h0040_0000, 32'h3F80_0000, 9'(-127), 4'b0000));
            vecs.push_back(mk(32'h0030_0000, 32'h3FC0_0000, 9'(-128), 4'b0000));
            vecs.push_back(mk(32'h8000_0001, 32'h3F80_0000, 9'd0,     4'b0010));
        end else begin
            vecs.push_back(mk(32'h0000_0001, 32'h3F80_0000, 9'd0, 4'b0001));
            vecs.push_back(mk(32'h0040_0000, 32'h3F80_0000, 9'd0, 4'b0001));
            vecs.push_back(mk(32'h8000_0001, 32'h3F80_0000, 9'd0, 4'b0001));
        end

        // Reset state
        tick();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset outputs", 64'({bus.m_out, bus.exp_out, bus.flags}), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back stream of 8 with out_ready held high
        exp_q.delete();
        mon_en = 1'b1;
        base = out_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.a = rand_operand();
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("b2b throughput", 64'(out_cnt - base), 64'd8);
        chk("b2b drained", 64'(exp_q.size()), 64'd0);

        // Stall: fill both stages, hold out_ready low 3 cycles, then release
        base = out_cnt;
        bus.out_ready = 1'b0;
        bus.a = rand_operand();
        bus.in_valid = 1'b1;
        tick();
        bus.a = rand_operand();
        tick();
        bus.a = rand_operand();
        for (int i = 0; i < 3; i++) begin
            chk("stall in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall out_valid", 64'(bus.out_valid), 64'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stall no loss", 64'(out_cnt - base), 64'd3);
        chk("stall drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        bus.a = 32'h4000_0000;
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("pre-reset busy", 64'(bus.busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("async reset busy", 64'(bus.busy), 64'd0);
        exp_q.delete();
        mon_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        run_vec(mk(32'h4100_0000, 32'h3F80_0000, 9'd3, 4'b0000));

        // Randomized stream with random backpressure against the model
        exp_q.delete();
        mon_en = 1'b1;
        bus.a = rand_operand();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                tick();
                bus.a = rand_operand();
            end else begin
                tick();
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("random drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/single_log2_range_reduce.md
Name: single_log2_range_reduce

Overview:
- Upstream range-reduction stage for the single-precision log2 path: splits an IEEE-754 single x into an unbiased exponent and a mantissa re-biased to [1.0, 2.0).
- The mantissa feeds the log2 one-to-two table; the exponent and special-case flags travel alongside to the final combine stage, which computes log2(x) = exp_out + log2(m_out).
- Two-stage valid/ready pipeline; normalises denormals and classifies specials.

Parameters:
- BITS, 32, operand width; only 32 supported.
- PRECISION, "SINGLE", format tag; only "SINGLE" supported.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  upstream data valid
- in_ready  output  1  block can accept a this cycle
- a  input  BITS  IEEE-754 single operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- m_out  output  BITS  single in [1.0, 2.0): {0, 8'd127, normalised mantissa}
- exp_out  output  9  signed unbiased exponent, range -149..127
- flags  output  4  {nan, inf, neg, zero}, one-hot or all zero
- busy  output  1  any stage holds valid data

Behaviour:
- Reset is asynchronous and active-high. On assertion, s1_valid, out_valid and busy go to 0 immediately. m_out=0, exp_out=0, flags=0.
- Transfer rules:
  - A transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv. This is combinational from out_ready; there is no skid buffer.
- Stage 1 register: captures sign, biased exponent E, mantissa M[22:0] and lz (leading zeros of M counted from bit 22; lz=23 when M=0).
- Stage 2 (output) register loads when s2_adv. out_valid <= s1_valid.
- Latency: 2 cycles from input transfer to out_valid. Throughput: 1 per cycle when out_ready=1.
- While out_valid && !out_ready: m_out, exp_out and flags hold stable; stage 1 holds if valid.
- Classification uses priority nan > zero > neg > inf > normal/denormal:
  - nan: E=255, M!=0.
  - zero: E=0, M=0, either sign.
  - neg: sign=1, not nan, not zero; includes -inf and negative denormals.
  - inf: +inf only.
- Any special: m_out=0x3F800000, exp_out=0, the single corresponding flag set.
- Normal, E in 1..254, sign 0: m_out={0,127,M}, exp_out=E-127, flags=0.
- Denormal, E=0, M!=0, sign 0:
  - shift = lz+1; m_out={0,127,(M<<shift)[22:0]}; exp_out = -127-lz.
  - Examples: M=1 gives exp_out=-149; M=0x400000 gives exp_out=-127 with mantissa 0.
- exp_out is two's complement, 9 bits; no saturation is needed since the range fits.
- busy = s1_valid | out_valid.
- Reset asserted mid-operation: in-flight data is discarded with no output. After deassertion, the first input is accepted on the first clock edge with in_valid high.

Optional Feature:
- Macro SINGLE_LOG2_DENORM_EN.
- Defined: denormals are normalised as above; the lz leading-zero logic is present.
- Undefined: denormals are flushed to zero. flags.zero=1, m_out=0x3F800000, exp_out=0; a negative denormal also reports zero, not neg. The leading-zero logic is omitted.
- Latency and handshake are identical in both builds.

Test Plan:
- a=0x40400000 (3.0), out_ready=1 -> 2 cycles later out_valid=1, m_out=0x3FC00000, exp_out=1, flags=0. a=0x3F800000 -> m_out=0x3F800000, exp_out=0.
- a=0x00000001 with SINGLE_LOG2_DENORM_EN -> m_out=0x3F800000, exp_out=-149, flags=0. Same input without the macro -> flags=4'b0001, exp_out=0.
- Special-case stream:
  - a=0x80000000 -> flags=0001.
  - a=0xBF800000 -> flags=0010.
  - a=0x7F800000 -> flags=0100.
  - a=0x7FC00000 -> flags=1000.
  - In every case m_out=0x3F800000 and exp_out=0.
- Back-to-back stream of 8 values with out_ready=1 -> one result per cycle, order preserved. Then hold out_ready=0 for 3 cycles:
  - in_ready drops once both stages are full;
  - output stays stable;
  - no loss or duplication after release.
- Assert reset asynchronously with both stages valid -> out_valid and busy go to 0 before the next clock edge. After release, a=0x41000000 (8.0) -> exp_out=3, m_out=0x3F800000.
- a=0x00400000 with SINGLE_LOG2_DENORM_EN -> m_out=0x3F800000, exp_out=-127. a=0x7F7FFFFF -> exp_out=127, m_out=0x3FFFFFFF.
